incr_pipe: RTL and testbench
============================

// Module: incr_pipe
//
// PURPOSE
// - Multi-lane registered incrementer: each of LANES words of WIDTH bits gets +in_step, in wrap or saturate mode.
// - Valid/ready elastic pipeline of STAGES registers; full throughput and backpressure.
// - Sits between the top-level I/O ports and the core.
//   Replaces the fixed small/quad/wide combinational "+1" output paths with one parametrised, registered datapath.
//
// PARAMETERS
// - WIDTH   default 40   bits per lane (>=2)
// - LANES   default 3    number of independent lanes (>=1)
// - STAGES  default 2    register stages input->output (>=1); sets latency
//
// PORTS
// - clk        in   1              sole clock, rising edge
// - reset_l    in   1              asynchronous assert, active-low reset; deassert synchronised upstream
// - in_valid   in   1              input beat present
// - in_ready   out  1              block accepts beat this cycle
// - in_data    in   LANES*WIDTH    lane i = bits [i*WIDTH +: WIDTH]
// - in_step    in   WIDTH          increment, sampled with the beat
// - sat_mode   in   1              1=saturate, 0=wrap; sampled with the beat
// - out_valid  out  1              output beat present
// - out_ready  in   1              downstream accepts beat
// - out_data   out  LANES*WIDTH    incremented lanes
// - out_ovf    out  LANES          per-lane carry-out of the add (set in both modes)
// - txn_count  out  32             count of accepted input beats
//
// BEHAVIOUR
// - Reset (reset_l=0, async): all stage valids=0, out_valid=0, out_data=0, out_ovf=0, txn_count=0. in_ready=1 once reset releases.
// - Accept: in_valid & in_ready at a clk edge. in_data, in_step and sat_mode are captured together.
//   Later changes to in_step or sat_mode never affect beats already in flight.
// - Arithmetic, in stage 0, per lane:
//   - sum = {1'b0,d} + {1'b0,step} (WIDTH+1 bits); ovf = sum[WIDTH].
//   - wrap: q = sum[WIDTH-1:0]; saturate: q = ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0].
//   - step=0 passes data through with ovf=0.
// - Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, when no stall occurs.
// - Stage handshake: stage s loads when its upstream is valid and (stage s empty, or stage s is draining this cycle).
//   - in_ready = ~v[0] | ready_into_stage1 (combinational ready chain; no bubbles).
// - Throughput: 1 beat/cycle with out_ready=1.
// - out_ready=0: stages fill, then in_ready drops.
//   - No beat is lost or duplicated.
//   - out_data, out_ovf and out_valid stay stable while out_valid & ~out_ready.
// - Ordering: strict FIFO; no reordering across lanes or beats.
// - txn_count increments by 1 on each accept and wraps 32'hFFFF_FFFF->0.
// - Reset mid-operation flushes all in-flight beats; none emerge after release.
// - in_valid may drop without a handshake; no protocol check is made on upstream.
//
// STRUCTURE
// - Package incr_pkg:
//   - typedef enum logic {INCR_WRAP=1'b0, INCR_SAT=1'b1} incr_mode_e
//   - function incr_lane(d, step, mode) returns {ovf, q}
// - Sub-module incr_stage: one elastic register stage (payload width param, v/rdy in/out, async reset_l).
//   - incr_pipe instantiates it STAGES times via generate.
//   - Stage 0 payload is the arithmetic result of incr_lane applied to all lanes.
// - txn_count register lives in incr_pipe.
//
// TESTING (WIDTH=8, LANES=3, STAGES=2 unless noted)
// 1. Wrap mode, in_data={8'h01,8'hFE,8'hFF}, step=1 -> out_data={02,FF,00}, out_ovf=3'b001, out_valid one edge after accept.
// 2. Saturate mode, lanes {F0,10,FF}, step=8'h20 -> out_data={FF,30,FF}, out_ovf=3'b101.
// 3. Streaming with out_ready=1: 100 back-to-back beats -> 100 outputs in order, no gaps after fill, txn_count=100.
// 4. Backpressure, out_ready=0 for 5 cycles with in_valid=1:
//    - in_ready drops after 2 beats; out_data holds stable.
//    - On release, all beats emerge in order with no loss or duplication.
// 5. Mid-flight change: step changes 1->5 and sat_mode toggles on the cycle after an accept -> in-flight beat uses step 1 and the old mode.
// 6. reset_l pulsed low with 2 beats in flight -> out_valid=0 and txn_count=0 immediately (async); no stale beat after release.
//    Repeat with STAGES=1 and WIDTH=70: carry across the 64-bit boundary (70'h0_FFFF_FFFF_FFFF_FFFF + 1).

Source files
------------

// File: rtl/incr_pkg.sv
// Shared types and lane arithmetic for the incr_pipe incrementer.
//   incr_mode_e : wrap / saturate selector
//   incr_lane() : one lane add returning the WIDTH-bit result with the carry-out
//                 just above it
package incr_pkg;

  // Widest lane incr_lane() can handle; lanes narrower than this are zero-extended.
  localparam int unsigned INCR_MAX_W = 128;

  typedef enum logic {INCR_WRAP = 1'b0, INCR_SAT = 1'b1} incr_mode_e;

  // Add step to d in a w-bit lane (w <= INCR_MAX_W). Operands must arrive
  // zero-extended above bit w-1. The result has q in bits [w-1:0] and ovf in
  // bit w, so a (w+1)-bit cast of the return value yields {ovf, q}.
  function automatic logic [INCR_MAX_W:0] incr_lane(
    input logic [INCR_MAX_W-1:0] d,
    input logic [INCR_MAX_W-1:0] step,
    input incr_mode_e            mode,
    input int unsigned           w
  );
    logic [INCR_MAX_W:0]   sum;
    logic [INCR_MAX_W-1:0] mask;
    logic [INCR_MAX_W-1:0] q;
    logic                  ovf;
    sum  = {1'b0, d} + {1'b0, step};
    mask = ~({INCR_MAX_W{1'b1}} << w);
    // sum < 2^(w+1), so anything left after shifting out the lane is the carry
    ovf  = |(sum >> w);
    q    = (ovf && (mode == INCR_SAT)) ? mask : (sum[INCR_MAX_W-1:0] & mask);
    return (INCR_MAX_W+1)'(q) | ((INCR_MAX_W+1)'(ovf) << w);
  endfunction

endpackage

// File: rtl/incr_stage.sv
// One elastic valid/ready register stage.
//   up_valid/up_data : beat offered from upstream
//   dn_ready         : downstream takes this stage's beat this cycle
//   dn_valid/dn_data : registered beat held by this stage
module incr_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          up_valid,
  input  logic [PW-1:0] up_data,
  input  logic          dn_ready,
  output logic          dn_valid,
  output logic [PW-1:0] dn_data
);

  logic          v_q, v_d;
  logic [PW-1:0] data_q, data_d;
  logic          load_c;

  // Load when empty or when the held beat leaves on this same edge.
  always_comb begin
    load_c = up_valid & (~v_q | dn_ready);
    v_d    = v_q;
    data_d = data_q;
    if (load_c) begin
      v_d    = 1'b1;
      data_d = up_data;
    end else if (dn_ready) begin
      v_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign dn_valid = v_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/incr_pipe.sv
// Multi-lane registered incrementer with a STAGES-deep elastic pipeline.
//   in_valid/in_ready/in_data/in_step/sat_mode : input beat and its controls
//   out_valid/out_ready/out_data/out_ovf       : incremented beat, per-lane carry
//   txn_count                                  : accepted input beats (wraps)
module incr_pipe
  import incr_pkg::*;
#(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned LANES  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]       in_step,
  input  logic                   sat_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic [31:0]            txn_count
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned PW = DW + LANES;

  // Index 0 is the pipeline input; index s+1 is the output of stage s.
  logic [STAGES:0] v_chain;
  logic [STAGES:0] rdy_c;
  logic [PW-1:0]   pl [STAGES+1];

  logic [DW-1:0]    sum_data_c;
  logic [LANES-1:0] sum_ovf_c;
  logic [WIDTH:0]   lane_c;
  logic             full_c;
  logic [31:0]      txn_q, txn_d;

  // Lane arithmetic feeding stage 0; step and mode travel with the beat.
  always_comb begin
    sum_data_c = '0;
    sum_ovf_c  = '0;
    lane_c     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_c = (WIDTH+1)'(incr_lane(INCR_MAX_W'(in_data[l*WIDTH +: WIDTH]),
                                    INCR_MAX_W'(in_step),
                                    incr_mode_e'(sat_mode), WIDTH));
      sum_data_c[l*WIDTH +: WIDTH] = lane_c[WIDTH-1:0];
      sum_ovf_c[l]                 = lane_c[WIDTH];
    end
  end

  assign v_chain[0] = in_valid;
  assign pl[0]      = {sum_ovf_c, sum_data_c};

  // Ready into stage s: output drains, or some stage from s onward has a hole.
  // Equivalent to the chained ~v | ready_next form, but built from the valids
  // directly so there is no combinational path through the chain itself.
  always_comb begin
    rdy_c         = '0;
    full_c        = 1'b1;
    rdy_c[STAGES] = out_ready;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      full_c   = full_c & v_chain[s+1];
      rdy_c[s] = out_ready | ~full_c;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    incr_stage #(.PW(PW)) u_stage (
      .clk      (clk),
      .reset_l  (reset_l),
      .up_valid (v_chain[s]),
      .up_data  (pl[s]),
      .dn_ready (rdy_c[s+1]),
      .dn_valid (v_chain[s+1]),
      .dn_data  (pl[s+1])
    );
  end

  assign in_ready = rdy_c[0];

  // Accepted-beat counter; wraps naturally at 32 bits.
  always_comb begin
    txn_d = txn_q;
    if (in_valid && rdy_c[0]) txn_d = txn_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) txn_q <= '0;
    else          txn_q <= txn_d;
  end

  assign txn_count = txn_q;
  assign out_valid = v_chain[STAGES];
  assign out_data  = pl[STAGES][DW-1:0];
  assign out_ovf   = pl[STAGES][PW-1:DW];

endmodule

// File: tb/tb_incr_pipe.sv
// Directed bench for incr_pipe: an 8-bit x3 lane, 2-stage instance plus a
// 70-bit x2 lane, single-stage instance for the wide carry case.
module tb_incr_pipe;

  logic        clk;
  logic        reset_l;
  logic        in_valid, in_ready, sat_mode, out_valid, out_ready;
  logic [23:0] in_data, out_data;
  logic [7:0]  in_step;
  logic [2:0]  out_ovf;
  logic [31:0] txn_count;

  logic         w_in_valid, w_in_ready, w_sat_mode, w_out_valid, w_out_ready;
  logic [139:0] w_in_data, w_out_data;
  logic [69:0]  w_in_step;
  logic [1:0]   w_out_ovf;
  logic [31:0]  w_txn_count;

  int checks = 0;
  int errors = 0;
  int acc_cnt, rx_cnt, gaps, stale;
  logic last_in_ready;
  logic [26:0] exp_q [$];
  logic [69:0] wl0, wl1;

  incr_pipe #(.WIDTH(8), .LANES(3), .STAGES(2)) dut (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_step(in_step), .sat_mode(sat_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .txn_count(txn_count)
  );

  incr_pipe #(.WIDTH(70), .LANES(2), .STAGES(1)) dut_w (
    .clk(clk), .reset_l(reset_l), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_step(w_in_step), .sat_mode(w_sat_mode),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .txn_count(w_txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference for the 8-bit x3 instance: {ovf[2:0], data[23:0]}.
  function automatic logic [26:0] model(input logic [23:0] d, input logic [7:0] st, input logic sat);
    logic [8:0]  s9;
    logic [26:0] r;
    r = '0;
    for (int l = 0; l < 3; l++) begin
      s9 = {1'b0, d[l*8 +: 8]} + {1'b0, st};
      r[l*8 +: 8] = (sat && s9[8]) ? 8'hFF : s9[7:0];
      r[24+l]     = s9[8];
    end
    return r;
  endfunction

  // Settle inputs, score the output beat, log the input accept, then cross an edge.
  task automatic tick();
    #1;
    last_in_ready = in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out_valid", out_valid, 1'b0);
      end else begin
        chk("sb_beat", {out_ovf, out_data}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          rx_cnt++;
        end
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data, in_step, sat_mode));
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l = 1'b1;
    in_valid = 1'b0; in_data = '0; in_step = '0; sat_mode = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_step = '0; w_sat_mode = 1'b0; w_out_ready = 1'b1;
    acc_cnt = 0; rx_cnt = 0; gaps = 0; stale = 0;

    // Reset state
    #2 reset_l = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_out_ovf", out_ovf, 3'b000);
    chk("rst_txn_count", txn_count, 32'd0);
    chk("rst_w_out_valid", w_out_valid, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset_l = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Test 1: wrap, step 1
    in_valid = 1'b1; in_data = 24'h01FEFF; in_step = 8'h01; sat_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t1_not_yet_valid", out_valid, 1'b0);
    tick();
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_data", out_data, 24'h02FF00);
    chk("t1_out_ovf", out_ovf, 3'b001);

    // Test 2: saturate, step 0x20
    in_valid = 1'b1; in_data = 24'hF010FF; in_step = 8'h20; sat_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_data", out_data, 24'hFF30FF);
    chk("t2_out_ovf", out_ovf, 3'b101);
    chk("t2_txn_count", txn_count, 32'd2);

    // Wide lanes, single stage: carry across bit 64
    wl0 = 70'h0_FFFF_FFFF_FFFF_FFFF;
    wl1 = 70'h3F_FFFF_FFFF_FFFF_FFFF;
    w_in_valid = 1'b1; w_in_data = {wl1, wl0}; w_in_step = 70'd1; w_sat_mode = 1'b0;
    tick();
    w_in_valid = 1'b0;
    chk("w_wrap_out_valid", w_out_valid, 1'b1);
    chk("w_wrap_out_data", w_out_data, {70'h0, 70'h1_0000_0000_0000_0000});
    chk("w_wrap_out_ovf", w_out_ovf, 2'b10);
    w_in_valid = 1'b1; w_sat_mode = 1'b1;
    tick();
    w_in_valid = 1'b0;
    chk("w_sat_out_data", w_out_data, {70'h3F_FFFF_FFFF_FFFF_FFFF, 70'h1_0000_0000_0000_0000});
    chk("w_sat_out_ovf", w_out_ovf, 2'b10);
    chk("w_txn_count", w_txn_count, 32'd2);

    // Test 5: controls change right after an accept
    in_valid = 1'b1; in_data = 24'h0010FF; in_step = 8'h01; sat_mode = 1'b0;
    tick();
    in_step = 8'h05; sat_mode = 1'b1;
    tick();
    chk("t5_old_beat_data", out_data, 24'h011100);
    chk("t5_old_beat_ovf", out_ovf, 3'b001);
    in_valid = 1'b0;
    tick();
    chk("t5_new_beat_data", out_data, 24'h0515FF);
    chk("t5_new_beat_ovf", out_ovf, 3'b001);
    chk("t5_txn_count", txn_count, 32'd4);

    // Test 3: 100 back-to-back beats
    tick(); tick();
    acc_cnt = 0; rx_cnt = 0; gaps = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200 && acc_cnt < 100; c++) begin
      in_data  = {8'(acc_cnt), 8'(acc_cnt * 3), 8'(255 - acc_cnt)};
      in_step  = 8'(acc_cnt % 7);
      sat_mode = 1'(acc_cnt % 2);
      tick();
      if (rx_cnt > 0 && !out_valid && exp_q.size() > 0) gaps++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    chk("t3_accepted", 32'(acc_cnt), 32'd100);
    chk("t3_received", 32'(rx_cnt), 32'd100);
    chk("t3_gaps", 32'(gaps), 32'd0);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_txn_count", txn_count, 32'd104);

    // Test 4: backpressure for 5 cycles
    acc_cnt = 0; rx_cnt = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_step = 8'h01; sat_mode = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data = {8'(8'h40 + c), 8'(8'h80 + c), 8'hFF};
      tick();
      chk("t4_in_ready", last_in_ready, (c < 2));
    end
    chk("t4_accepted", 32'(acc_cnt), 32'd2);
    chk("t4_held_valid", out_valid, 1'b1);
    chk("t4_held_data", out_data, 24'h418100);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    chk("t4_received", 32'(rx_cnt), 32'd2);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_txn_count", txn_count, 32'd106);

    // Test 6: async reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; in_data = 24'h123456;
    tick(); tick();
    in_valid = 1'b0;
    #1 reset_l = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_txn_count", txn_count, 32'd0);
    chk("t6_out_data", out_data, 24'h0);
    chk("t6_w_txn_count", w_txn_count, 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset_l = 1'b1; out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("t6_no_stale_beat", 32'(stale), 32'd0);
    chk("t6_txn_after", txn_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
